// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encodings, frame geometry and the checksum update helper.
package imem_boot_loader_pkg;

    // Payload bytes packed into one instruction word
    localparam int BYTES_PER_WORD = 4;

    // Loader states; S_RUN and S_ERR are terminal until reset
    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_RUN    = 3'd4,
        S_ERR    = 3'd5
    } boot_state_t;

    // Running frame checksum: XOR of every payload byte
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Packs a strobed byte stream into little-endian 32-bit words. The first
// byte of a word lands in bits [7:0]; word_valid pulses combinationally
// together with the strobe of the 4th byte so the caller can register it.
import imem_boot_loader_pkg::*;

module byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_stb,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  byte_cnt_r;
    logic [23:0] shift_r;

    // Count bytes within the word and shift earlier bytes toward bit 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_cnt_r <= 2'd0;
            shift_r    <= 24'd0;
        end else if (byte_stb) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            shift_r    <= {byte_data, shift_r[23:8]};
        end else begin
            byte_cnt_r <= byte_cnt_r;
            shift_r    <= shift_r;
        end
    end

    // Word is complete when the strobe carries the last byte of the word
    always_comb begin
        word_valid = byte_stb && (byte_cnt_r == LAST_IDX);
        word       = {byte_data, shift_r};
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed program image over
// a byte stream, writes it word by word into instruction memory and releases
// the CPU reset only after the whole image has been checked.
import imem_boot_loader_pkg::*;

module imem_boot_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err
);

    localparam int          CNT_W     = ADDR_W + 1;
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    boot_state_t       state_r;
    boot_state_t       next_state_s;
    logic              rx_ready_s;
    logic              accept_s;
    logic              byte_stb_s;
    logic              word_valid_s;
    logic [31:0]       word_s;
    logic [15:0]       len_s;
    logic              len_bad_s;
    logic              last_word_s;
    logic [7:0]        len_lo_r;
    logic [7:0]        xor_r;
    logic [CNT_W-1:0]  word_cnt_r;
    logic [CNT_W-1:0]  last_word_r;
    logic              imem_we_r;
    logic [ADDR_W-1:0] imem_addr_r;
    logic [DATA_W-1:0] imem_wdata_r;
    logic              cpu_rst_r;
    logic              load_err_r;

    byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_stb   (byte_stb_s),
        .byte_data  (rx_data),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // Length decode: word count is zero or exceeds memory capacity
    always_comb begin
        len_s       = {rx_data, len_lo_r};
        len_bad_s   = (len_s == 16'd0) || ({1'b0, len_s} > MAX_WORDS);
        last_word_s = (word_cnt_r == last_word_r);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_LEN_LO;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_LEN_LO: begin
                if (accept_s) next_state_s = S_LEN_HI;
                else          next_state_s = state_r;
            end
            S_LEN_HI: begin
                if (accept_s) next_state_s = len_bad_s ? S_ERR : S_DATA;
                else          next_state_s = state_r;
            end
            S_DATA: begin
                if (word_valid_s && last_word_s) next_state_s = S_CSUM;
                else                             next_state_s = state_r;
            end
            S_CSUM: begin
                if (accept_s) next_state_s = (rx_data == xor_r) ? S_RUN : S_ERR;
                else          next_state_s = state_r;
            end
            S_RUN:   next_state_s = S_RUN;
            S_ERR:   next_state_s = S_ERR;
            default: next_state_s = S_ERR;
        endcase
    end

    // FSM outputs: handshake ready and payload byte strobe
    always_comb begin
        rx_ready_s = 1'b0;
        case (state_r)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: rx_ready_s = rst;
            default:                            rx_ready_s = 1'b0;
        endcase
        accept_s   = rx_valid && rx_ready_s;
        byte_stb_s = accept_s && (state_r == S_DATA);
    end

    // Frame bookkeeping: length capture, word counter, checksum accumulator
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_lo_r    <= 8'd0;
            last_word_r <= {CNT_W{1'b0}};
            word_cnt_r  <= {CNT_W{1'b0}};
            xor_r       <= 8'd0;
        end else begin
            if (accept_s && (state_r == S_LEN_LO)) len_lo_r <= rx_data;
            if (accept_s && (state_r == S_LEN_HI)) last_word_r <= CNT_W'(len_s - 16'd1);
            if (byte_stb_s)   xor_r      <= csum_update(xor_r, rx_data);
            if (word_valid_s) word_cnt_r <= word_cnt_r + CNT_W'(1);
        end
    end

    // Registered memory write port and CPU release/status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            imem_we_r    <= 1'b0;
            imem_addr_r  <= {ADDR_W{1'b0}};
            imem_wdata_r <= {DATA_W{1'b0}};
            cpu_rst_r    <= 1'b0;
            load_err_r   <= 1'b0;
        end else begin
            imem_we_r <= word_valid_s;
            if (word_valid_s) begin
                imem_addr_r  <= word_cnt_r[ADDR_W-1:0];
                imem_wdata_r <= word_s;
            end
            cpu_rst_r  <= (next_state_s == S_RUN);
            load_err_r <= (next_state_s == S_ERR);
        end
    end

    assign rx_ready   = rx_ready_s;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign cpu_rst    = cpu_rst_r;
    assign load_done  = cpu_rst_r;
    assign load_err   = load_err_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed frames plus randomized
// frames checked against a frame-level reference model.
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_rst;
    logic              load_done;
    logic              load_err;

    imem_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Observed writes and protocol-rule violations collected on the falling edge
    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];
    int                we_run_viol  = 0;
    int                hold_viol    = 0;
    int                overlap_viol = 0;
    logic              prev_we    = 1'b0;
    logic              prev_rst   = 1'b0;
    logic [31:0]       prev_wdata = 32'd0;

    always @(negedge clk) begin
        if (rst && imem_we === 1'b1) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
        end
        if (rst && prev_rst && imem_we && prev_we) we_run_viol++;
        if (rst && prev_rst && !imem_we && (imem_wdata !== prev_wdata)) hold_viol++;
        if (cpu_rst === 1'b1 && imem_we === 1'b1) overlap_viol++;
        prev_we    = imem_we;
        prev_rst   = rst;
        prev_wdata = imem_wdata;
    end

    // Reference model state for the current frame
    logic [7:0]        frame[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    bit                exp_done;
    bit                exp_err;
    int                exp_acc;

    // Frame-level model: which words get written, how many bytes are taken, final status
    task automatic model_frame();
        int n;
        logic [7:0]  cs;
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_acc  = frame.size();
        if (frame.size() < 2) return;
        n = int'({frame[1], frame[0]});
        if (n == 0 || n > (1 << ADDR_W)) begin
            exp_err = 1'b1;
            exp_acc = 2;
            return;
        end
        cs = 8'd0;
        for (int i = 0; i < n; i++) begin
            if (2 + 4 * i + 3 >= frame.size()) return;
            w  = {frame[5 + 4 * i], frame[4 + 4 * i], frame[3 + 4 * i], frame[2 + 4 * i]};
            cs = cs ^ frame[2 + 4 * i] ^ frame[3 + 4 * i] ^ frame[4 + 4 * i] ^ frame[5 + 4 * i];
            exp_addr.push_back(ADDR_W'(i));
            exp_data.push_back(w);
        end
        if (2 + 4 * n >= frame.size()) return;
        exp_acc = 3 + 4 * n;
        if (frame[2 + 4 * n] == cs) exp_done = 1'b1;
        else                        exp_err  = 1'b1;
    endtask

    // Offer each frame byte with optional idle gaps; a byte not taken within 6 cycles is dropped
    task automatic send_frame(input int gap_mode, output int n_acc);
        logic rdy;
        logic acc;
        int   k;
        n_acc = 0;
        foreach (frame[i]) begin
            k = 0;
            if (gap_mode == 1 && i > 0) k = 1;
            if (gap_mode == 2) k = $urandom_range(0, 2);
            rx_valid = 1'b0;
            repeat (k) @(posedge clk);
            #1;
            rx_valid = 1'b1;
            rx_data  = frame[i];
            acc = 1'b0;
            for (int t = 0; t < 6 && !acc; t++) begin
                @(negedge clk);
                rdy = rx_ready;
                @(posedge clk);
                #1;
                acc = rdy;
            end
            if (acc) n_acc++;
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rst = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b1;
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic load_two_word_frame(input logic [7:0] csum);
        frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'hEF, 8'hBE, 8'hAD, 8'hDE, csum};
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            total++; if (rx_ready !== 1'b0)  begin bad++; $display("FAIL reset_rx_ready cyc%0d: got %b want 0", c, rx_ready); end
            total++; if (imem_we !== 1'b0)   begin bad++; $display("FAIL reset_imem_we cyc%0d: got %b want 0", c, imem_we); end
            total++; if (cpu_rst !== 1'b0)   begin bad++; $display("FAIL reset_cpu_rst cyc%0d: got %b want 0", c, cpu_rst); end
            total++; if (load_done !== 1'b0) begin bad++; $display("FAIL reset_load_done cyc%0d: got %b want 0", c, load_done); end
            total++; if (load_err !== 1'b0)  begin bad++; $display("FAIL reset_load_err cyc%0d: got %b want 0", c, load_err); end
        end
        total++; if (imem_addr !== 8'd0 || imem_wdata !== 32'd0) begin bad++; $display("FAIL reset_wport: got addr %h data %h want 0 0", imem_addr, imem_wdata); end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_two_words();
        int n_acc;
        do_reset(1);
        load_two_word_frame(8'h31);
        model_frame();
        send_frame(0, n_acc);
        @(negedge clk);
        total++; if (cpu_rst !== 1'b1)   begin bad++; $display("FAIL two_cpu_rst: got %b want 1", cpu_rst); end
        total++; if (load_done !== 1'b1) begin bad++; $display("FAIL two_load_done: got %b want 1", load_done); end
        total++; if (load_err !== 1'b0)  begin bad++; $display("FAIL two_load_err: got %b want 0", load_err); end
        total++; if (rx_ready !== 1'b0)  begin bad++; $display("FAIL two_rx_ready: got %b want 0", rx_ready); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (n_acc != exp_acc) begin bad++; $display("FAIL two_accepted: got %0d want %0d", n_acc, exp_acc); end
        total++; if (got_data.size() != 2) begin bad++; $display("FAIL two_nwrites: got %0d want 2", got_data.size()); end
        if (got_data.size() == 2) begin
            total++; if (got_addr[0] !== 8'd0 || got_data[0] !== 32'h00000013) begin bad++; $display("FAIL two_word0: got %h@%h want 00000013@00", got_data[0], got_addr[0]); end
            total++; if (got_addr[1] !== 8'd1 || got_data[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL two_word1: got %h@%h want deadbeef@01", got_data[1], got_addr[1]); end
        end
    endtask

    task automatic test_bad_csum();
        int n_acc;
        do_reset(1);
        load_two_word_frame(8'h30);
        frame.push_back(8'h55);
        frame.push_back(8'hAA);
        frame.push_back(8'h01);
        model_frame();
        send_frame(0, n_acc);
        @(negedge clk);
        total++; if (load_err !== 1'b1)  begin bad++; $display("FAIL csum_load_err: got %b want 1", load_err); end
        total++; if (cpu_rst !== 1'b0)   begin bad++; $display("FAIL csum_cpu_rst: got %b want 0", cpu_rst); end
        total++; if (load_done !== 1'b0) begin bad++; $display("FAIL csum_load_done: got %b want 0", load_done); end
        total++; if (rx_ready !== 1'b0)  begin bad++; $display("FAIL csum_rx_ready: got %b want 0", rx_ready); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (n_acc != exp_acc) begin bad++; $display("FAIL csum_accepted: got %0d want %0d", n_acc, exp_acc); end
        total++; if (got_data.size() != exp_data.size()) begin bad++; $display("FAIL csum_nwrites: got %0d want %0d", got_data.size(), exp_data.size()); end
    endtask

    task automatic test_bad_len();
        int n_acc;
        logic [7:0] lens[4];
        lens = '{8'h00, 8'h00, 8'h01, 8'h01};
        for (int j = 0; j < 2; j++) begin
            do_reset(1);
            frame = '{lens[2 * j], lens[2 * j + 1], 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
            model_frame();
            send_frame(0, n_acc);
            @(negedge clk);
            total++; if (load_err !== 1'b1) begin bad++; $display("FAIL len%0d_load_err: got %b want 1", j, load_err); end
            total++; if (cpu_rst !== 1'b0)  begin bad++; $display("FAIL len%0d_cpu_rst: got %b want 0", j, cpu_rst); end
            total++; if (n_acc != exp_acc)  begin bad++; $display("FAIL len%0d_accepted: got %0d want %0d", j, n_acc, exp_acc); end
            total++; if (got_data.size() != 0) begin bad++; $display("FAIL len%0d_nwrites: got %0d want 0", j, got_data.size()); end
        end
    endtask

    task automatic test_gaps();
        int n_acc;
        do_reset(1);
        load_two_word_frame(8'h31);
        model_frame();
        send_frame(1, n_acc);
        @(negedge clk);
        total++; if (load_done !== 1'b1 || cpu_rst !== 1'b1) begin bad++; $display("FAIL gaps_done: got done %b cpu %b want 1 1", load_done, cpu_rst); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (got_data.size() != exp_data.size()) begin bad++; $display("FAIL gaps_nwrites: got %0d want %0d", got_data.size(), exp_data.size()); end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            total++; if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin bad++; $display("FAIL gaps_word%0d: got %h@%h want %h@%h", i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int n_acc;
        do_reset(1);
        load_two_word_frame(8'h31);
        frame = frame[0:4];
        send_frame(0, n_acc);
        rx_valid = 1'b1;
        rx_data  = 8'hEF;
        rst = 1'b0;
        @(negedge clk);
        total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL mid_rx_ready_in_reset: got %b want 0", rx_ready); end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++; if (cpu_rst !== 1'b0 || load_err !== 1'b0) begin bad++; $display("FAIL mid_status: got cpu %b err %b want 0 0", cpu_rst, load_err); end
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL mid_rx_ready_after: got %b want 1", rx_ready); end
        @(posedge clk);
        #1;
        got_addr.delete();
        got_data.delete();
        load_two_word_frame(8'h31);
        model_frame();
        send_frame(0, n_acc);
        @(negedge clk);
        total++; if (load_done !== 1'b1) begin bad++; $display("FAIL mid_reload_done: got %b want 1", load_done); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (got_data.size() != exp_data.size()) begin bad++; $display("FAIL mid_nwrites: got %0d want %0d", got_data.size(), exp_data.size()); end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            total++; if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin bad++; $display("FAIL mid_word%0d: got %h@%h want %h@%h", i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]); end
        end
    endtask

    task automatic test_random();
        int n_acc;
        int n;
        int kind;
        logic [7:0] cs;
        logic [7:0] b;
        for (int r = 0; r < 40; r++) begin
            do_reset($urandom_range(1, 2));
            kind = $urandom_range(0, 9);
            if (r == 0)         n = 1 << ADDR_W;
            else if (kind == 0) n = 0;
            else if (kind == 1) n = $urandom_range((1 << ADDR_W) + 1, 65535);
            else                n = $urandom_range(1, 12);
            frame.delete();
            frame.push_back(8'(n));
            frame.push_back(8'(n >> 8));
            cs = 8'd0;
            if (n >= 1 && n <= (1 << ADDR_W)) begin
                for (int i = 0; i < 4 * n; i++) begin
                    b = 8'($urandom);
                    cs = cs ^ b;
                    frame.push_back(b);
                end
                if ($urandom_range(0, 3) == 0) cs = cs ^ (8'd1 << $urandom_range(0, 7));
                frame.push_back(cs);
            end else begin
                for (int i = 0; i < 3; i++) frame.push_back(8'($urandom));
            end
            frame.push_back(8'($urandom));
            frame.push_back(8'($urandom));
            model_frame();
            send_frame($urandom_range(0, 2), n_acc);
            @(negedge clk);
            total++; if (load_done !== exp_done || cpu_rst !== exp_done) begin bad++; $display("FAIL rnd%0d_done: got done %b cpu %b want %b", r, load_done, cpu_rst, exp_done); end
            total++; if (load_err !== exp_err) begin bad++; $display("FAIL rnd%0d_err: got %b want %b", r, load_err, exp_err); end
            total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL rnd%0d_rx_ready: got %b want 0", r, rx_ready); end
            repeat (2) @(posedge clk);
            #1;
            total++; if (n_acc != exp_acc) begin bad++; $display("FAIL rnd%0d_accepted: got %0d want %0d", r, n_acc, exp_acc); end
            total++; if (got_data.size() != exp_data.size()) begin bad++; $display("FAIL rnd%0d_nwrites: got %0d want %0d", r, got_data.size(), exp_data.size()); end
            for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
                total++; if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin bad++; $display("FAIL rnd%0d_word%0d: got %h@%h want %h@%h", r, i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]); end
            end
        end
    endtask

    task automatic test_protocol_rules();
        total++; if (we_run_viol != 0)  begin bad++; $display("FAIL we_single_cycle: got %0d multi-cycle strobes want 0", we_run_viol); end
        total++; if (hold_viol != 0)    begin bad++; $display("FAIL wdata_hold: got %0d changes while idle want 0", hold_viol); end
        total++; if (overlap_viol != 0) begin bad++; $display("FAIL release_after_write: got %0d overlaps want 0", overlap_viol); end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_bad_csum();
        test_bad_len();
        test_gaps();
        test_reset_mid();
        test_random();
        test_protocol_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
